// File: rtl/module_demux_sp.sv
// Serial-to-parallel I/Q demultiplexer: re-pairs tagged I/Q words, buffers the
// pairs in a show-ahead FIFO and counts sequence errors and overflow drops.
module module_demux_sp #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         Data_In,
    input  logic                          Data_In_Valid,
    input  logic [3:0]                    Data_In_ChIdx,
    output logic [DATA_WIDTH-1:0]         Data_Out_I,
    output logic [DATA_WIDTH-1:0]         Data_Out_Q,
    output logic                          Data_Out_Valid,
    input  logic                          Data_Out_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
    output logic [CNT_WIDTH-1:0]          Seq_Err_Cnt,
    output logic [CNT_WIDTH-1:0]          Drop_Cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [DATA_WIDTH-1:0]       iHold_q, iHold_d;
    logic [AW-1:0]               wrPtr_q, wrPtr_d;
    logic [AW-1:0]               rdPtr_q, rdPtr_d;
    logic [LW-1:0]               level_q, level_d;
    logic [CNT_WIDTH-1:0]        seqErrCnt_q, seqErrCnt_d;
    logic [CNT_WIDTH-1:0]        dropCnt_q, dropCnt_d;
    logic [2*DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0]     headWord;

    logic isI, isQ, pairDone, seqErr;
    logic full, empty, push, pop, drop;

    assign isI = Data_In_Valid && (Data_In_ChIdx == 4'd1);
    assign isQ = Data_In_Valid && (Data_In_ChIdx == 4'd2);

    always_comb begin
        state_d  = state_q;
        iHold_d  = iHold_q;
        pairDone = 1'b0;
        seqErr   = 1'b0;
        case (state_q)
            WAIT_I: begin
                if (isI) begin
                    iHold_d = Data_In;
                    state_d = WAIT_Q;
                end else if (isQ) begin
                    seqErr = 1'b1;
                end
            end
            WAIT_Q: begin
                if (isQ) begin
                    pairDone = 1'b1;
                    state_d  = WAIT_I;
                end else if (isI) begin
                    iHold_d = Data_In;
                    seqErr  = 1'b1;
                end
            end
            default: state_d = WAIT_I;
        endcase
    end

    // A full FIFO still accepts a pair when the head leaves in the same cycle.
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign pop   = !empty && Data_Out_Ready;
    assign push  = pairDone && (!full || pop);
    assign drop  = pairDone && !push;

    always_comb begin
        wrPtr_d     = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d     = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        level_d     = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        if (pop && !push) level_d = level_q - LW'(1);
        seqErrCnt_d = (seqErr && (seqErrCnt_q != '1)) ? seqErrCnt_q + CNT_WIDTH'(1) : seqErrCnt_q;
        dropCnt_d   = (drop && (dropCnt_q != '1)) ? dropCnt_q + CNT_WIDTH'(1) : dropCnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= WAIT_I;
            iHold_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            seqErrCnt_q <= '0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            iHold_q     <= iHold_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            seqErrCnt_q <= seqErrCnt_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wrPtr_q] <= {iHold_q, Data_In};
    end

    // Storage is not reset, so the head is masked to zero whenever nothing is valid.
    assign headWord       = mem[rdPtr_q];
    assign Data_Out_Valid = !empty;
    assign Data_Out_I     = Data_Out_Valid ? headWord[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign Data_Out_Q     = Data_Out_Valid ? headWord[DATA_WIDTH-1:0] : '0;
    assign Fifo_Level     = level_q;
    assign Seq_Err_Cnt    = seqErrCnt_q;
    assign Drop_Cnt       = dropCnt_q;

endmodule

// File: tb/tb_module_demux_sp.sv
// Directed self-checking bench for module_demux_sp: inputs change on the falling
// edge, so outputs seen right after a drive reflect the previous rising edge.
module tb_module_demux_sp;

    logic        CLK;
    logic        RST;
    logic [23:0] Data_In;
    logic        Data_In_Valid;
    logic [3:0]  Data_In_ChIdx;
    logic [23:0] Data_Out_I;
    logic [23:0] Data_Out_Q;
    logic        Data_Out_Valid;
    logic        Data_Out_Ready;
    logic [2:0]  Fifo_Level;
    logic [7:0]  Seq_Err_Cnt;
    logic [7:0]  Drop_Cnt;

    int assertCount = 0;
    int failCount   = 0;

    module_demux_sp #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .Data_In(Data_In),
        .Data_In_Valid(Data_In_Valid),
        .Data_In_ChIdx(Data_In_ChIdx),
        .Data_Out_I(Data_Out_I),
        .Data_Out_Q(Data_Out_Q),
        .Data_Out_Valid(Data_Out_Valid),
        .Data_Out_Ready(Data_Out_Ready),
        .Fifo_Level(Fifo_Level),
        .Seq_Err_Cnt(Seq_Err_Cnt),
        .Drop_Cnt(Drop_Cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic applyStimulus(input logic v, input logic [3:0] ch, input logic [23:0] d, input logic rdy);
        @(negedge CLK);
        Data_In_Valid  = v;
        Data_In_ChIdx  = ch;
        Data_In        = d;
        Data_Out_Ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPair(input string tag, input logic [23:0] expI, input logic [23:0] expQ);
        checkOutput({tag, "_valid"}, {31'd0, Data_Out_Valid}, 32'd1);
        checkOutput({tag, "_I"}, {8'd0, Data_Out_I}, {8'd0, expI});
        checkOutput({tag, "_Q"}, {8'd0, Data_Out_Q}, {8'd0, expQ});
    endtask

    initial begin
        RST            = 1'b1;
        Data_In        = '0;
        Data_In_Valid  = 1'b0;
        Data_In_ChIdx  = '0;
        Data_Out_Ready = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_valid", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("rst_I", {8'd0, Data_Out_I}, 32'd0);
        checkOutput("rst_Q", {8'd0, Data_Out_Q}, 32'd0);
        checkOutput("rst_level", {29'd0, Fifo_Level}, 32'd0);
        checkOutput("rst_seqerr", {24'd0, Seq_Err_Cnt}, 32'd0);
        checkOutput("rst_drop", {24'd0, Drop_Cnt}, 32'd0);
        RST = 1'b0;

        // Basic pairing
        applyStimulus(1, 1, 24'h000001, 1);
        applyStimulus(1, 2, 24'hFFFFFF, 1);
        checkOutput("basic_noearly", {31'd0, Data_Out_Valid}, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkPair("basic", 24'h000001, 24'hFFFFFF);
        checkOutput("basic_level", {29'd0, Fifo_Level}, 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("basic_drained", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("basic_seqerr", {24'd0, Seq_Err_Cnt}, 32'd0);
        checkOutput("basic_drop", {24'd0, Drop_Cnt}, 32'd0);

        // Sequence errors
        applyStimulus(1, 2, 24'h10, 1);
        applyStimulus(1, 1, 24'h20, 1);
        checkOutput("seq_orphanq", {24'd0, Seq_Err_Cnt}, 32'd1);
        applyStimulus(1, 1, 24'h30, 1);
        checkOutput("seq_nopair1", {31'd0, Data_Out_Valid}, 32'd0);
        applyStimulus(1, 2, 24'h40, 1);
        checkOutput("seq_nopair2", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("seq_errcnt2", {24'd0, Seq_Err_Cnt}, 32'd2);
        applyStimulus(0, 0, 0, 1);
        checkPair("seq", 24'h30, 24'h40);
        applyStimulus(0, 0, 0, 1);
        checkOutput("seq_onepair", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("seq_errfinal", {24'd0, Seq_Err_Cnt}, 32'd2);

        // Overflow: six pairs into a four-deep FIFO with no drain
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 1, 24'h100 + 24'(k), 0);
            applyStimulus(1, 2, 24'h200 + 24'(k), 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("ovf_level", {29'd0, Fifo_Level}, 32'd4);
        checkOutput("ovf_drop", {24'd0, Drop_Cnt}, 32'd2);
        checkPair("ovf_head", 24'h100, 24'h200);
        applyStimulus(0, 0, 0, 0);
        checkPair("ovf_stable", 24'h100, 24'h200);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 1);
            checkPair($sformatf("ovf_drain%0d", k), 24'h100 + 24'(k), 24'h200 + 24'(k));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("ovf_empty", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("ovf_level0", {29'd0, Fifo_Level}, 32'd0);

        // Full FIFO with a pop in the same cycle a pair completes
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 24'h300 + 24'(k), 0);
            applyStimulus(1, 2, 24'h400 + 24'(k), 0);
        end
        applyStimulus(1, 1, 24'h305, 0);
        checkOutput("full_level", {29'd0, Fifo_Level}, 32'd4);
        applyStimulus(1, 2, 24'h405, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fullpop_level", {29'd0, Fifo_Level}, 32'd4);
        checkOutput("fullpop_drop", {24'd0, Drop_Cnt}, 32'd2);
        checkOutput("fullpop_seqerr", {24'd0, Seq_Err_Cnt}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 1);
            if (k < 3) checkPair($sformatf("fullpop_drain%0d", k), 24'h301 + 24'(k), 24'h401 + 24'(k));
            else       checkPair("fullpop_drain3", 24'h305, 24'h405);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("fullpop_empty", {31'd0, Data_Out_Valid}, 32'd0);

        // Mid-operation reset while in WAIT_Q with two pairs buffered
        applyStimulus(1, 1, 24'h500, 0);
        applyStimulus(1, 2, 24'h501, 0);
        applyStimulus(1, 1, 24'h502, 0);
        applyStimulus(1, 2, 24'h503, 0);
        applyStimulus(1, 1, 24'h600, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_rst_level", {29'd0, Fifo_Level}, 32'd2);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_valid", {31'd0, Data_Out_Valid}, 32'd0);
        checkOutput("async_I", {8'd0, Data_Out_I}, 32'd0);
        checkOutput("async_Q", {8'd0, Data_Out_Q}, 32'd0);
        checkOutput("async_level", {29'd0, Fifo_Level}, 32'd0);
        checkOutput("async_seqerr", {24'd0, Seq_Err_Cnt}, 32'd0);
        checkOutput("async_drop", {24'd0, Drop_Cnt}, 32'd0);
        applyStimulus(0, 0, 0, 1);
        RST = 1'b0;
        applyStimulus(1, 2, 24'h700, 1);
        applyStimulus(1, 1, 24'h701, 1);
        checkOutput("postrst_nopair", {31'd0, Data_Out_Valid}, 32'd0);
        applyStimulus(1, 2, 24'h702, 1);
        applyStimulus(0, 0, 0, 1);
        checkPair("postrst", 24'h701, 24'h702);
        checkOutput("postrst_seqerr", {24'd0, Seq_Err_Cnt}, 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("postrst_onepair", {31'd0, Data_Out_Valid}, 32'd0);

        // Ignored channel indices inside a pair, then counter saturation
        applyStimulus(1, 1, 24'h800, 1);
        applyStimulus(1, 0, 24'h999, 1);
        applyStimulus(1, 5, 24'h888, 1);
        applyStimulus(0, 2, 24'h777, 1);
        applyStimulus(1, 2, 24'h801, 1);
        checkOutput("ign_nopair", {31'd0, Data_Out_Valid}, 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkPair("ign", 24'h800, 24'h801);
        checkOutput("ign_seqerr", {24'd0, Seq_Err_Cnt}, 32'd1);
        for (int k = 0; k < 253; k++) applyStimulus(1, 2, 24'(k), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("sat_254", {24'd0, Seq_Err_Cnt}, 32'd254);
        for (int k = 0; k < 47; k++) applyStimulus(1, 2, 24'(k), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("sat_255", {24'd0, Seq_Err_Cnt}, 32'd255);
        checkOutput("sat_drop", {24'd0, Drop_Cnt}, 32'd0);
        checkOutput("sat_nopair", {31'd0, Data_Out_Valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
